// File: rtl/hpdmc_oddr_serializer.sv
// DDR write-data launcher: buffers write words and frames them as
// ODDR2 D0/D1 data, masks and DQS with preamble/postamble.
//
// Ports:
//   sys_clk, sys_rst      clock and async active-high reset
//   wr_valid/wr_ready     write word handshake into the FIFO
//   wr_data, wr_mask      {D1,D0} data and byte masks (1 = masked)
//   wr_last               final word of a burst
//   clr_underrun          clears the sticky underrun flag
//   dq_d0/dq_d1           rising/falling data to ODDR2
//   dm_d0/dm_d1           rising/falling masks to ODDR2
//   dq_oe, dqs_oe         DQ/DM and DQS output enables
//   dqs_d0/dqs_d1         DQS pattern to ODDR2
//   busy, underrun        activity and sticky underrun status
module hpdmc_oddr_serializer #(
  parameter int   DQ_WIDTH    = 16,
  parameter int   DEPTH       = 4,
  parameter int   START_LEVEL = 2,
  parameter logic INIT        = 1'b0
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [2*DQ_WIDTH-1:0]   wr_data,
  input  logic [DQ_WIDTH/4-1:0]   wr_mask,
  input  logic                    wr_last,
  input  logic                    clr_underrun,
  output logic [DQ_WIDTH-1:0]     dq_d0,
  output logic [DQ_WIDTH-1:0]     dq_d1,
  output logic [DQ_WIDTH/8-1:0]   dm_d0,
  output logic [DQ_WIDTH/8-1:0]   dm_d1,
  output logic                    dq_oe,
  output logic                    dqs_d0,
  output logic                    dqs_d1,
  output logic                    dqs_oe,
  output logic                    busy,
  output logic                    underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int MW = DQ_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE, PRE, DATA, POST
  } state_t;

  logic [2*DQ_WIDTH-1:0] mem_data [DEPTH];
  logic [2*MW-1:0]       mem_mask [DEPTH];
  logic                  mem_last [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] lcnt_q, lcnt_d;

  state_t state_q, state_d;

  logic [DQ_WIDTH-1:0] dq0_q, dq0_d;
  logic [DQ_WIDTH-1:0] dq1_q, dq1_d;
  logic [MW-1:0]       dm0_q, dm0_d;
  logic [MW-1:0]       dm1_q, dm1_d;
  logic                dqoe_q, dqoe_d;
  logic                dqs0_q, dqs0_d;
  logic                dqs1_q, dqs1_d;
  logic                dqsoe_q, dqsoe_d;
  logic                lbeat_q, lbeat_d;
  logic                ur_q, ur_d;

  logic push, pop, set_ur, start;

  assign wr_ready = (count_q != CW'(DEPTH));
  assign push     = wr_valid & wr_ready;
  assign start    = (count_q >= CW'(START_LEVEL))
                  | (lcnt_q != '0);

  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem_data[wptr_q] <= wr_data;
      mem_mask[wptr_q] <= wr_mask;
      mem_last[wptr_q] <= wr_last;
    end
  end

  // lbeat_q marks that the beat on the pins came from a
  // last-flagged entry; the burst ends one edge later unless
  // another entry is already queued.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    set_ur  = 1'b0;
    dq0_d   = {DQ_WIDTH{INIT}};
    dq1_d   = {DQ_WIDTH{INIT}};
    dm0_d   = '1;
    dm1_d   = '1;
    dqoe_d  = 1'b0;
    dqs0_d  = 1'b0;
    dqs1_d  = 1'b0;
    dqsoe_d = 1'b0;
    lbeat_d = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = PRE;
      PRE:  state_d = DATA;
      DATA: if (lbeat_q && count_q == '0)
              state_d = POST;
      POST: state_d = start ? PRE : IDLE;
      default: state_d = IDLE;
    endcase
    unique case (state_d)
      PRE:  dqsoe_d = 1'b1;
      DATA: begin
        dqoe_d  = 1'b1;
        dqsoe_d = 1'b1;
        dqs0_d  = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          dq0_d   = mem_data[rptr_q][DQ_WIDTH-1:0];
          dq1_d   = mem_data[rptr_q][2*DQ_WIDTH-1:DQ_WIDTH];
          dm0_d   = mem_mask[rptr_q][MW-1:0];
          dm1_d   = mem_mask[rptr_q][2*MW-1:MW];
          lbeat_d = mem_last[rptr_q];
        end else begin
          set_ur = 1'b1;
          dq0_d  = dq0_q;
          dq1_d  = dq1_q;
        end
      end
      POST: dqsoe_d = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    lcnt_d = lcnt_q;
    if (push && wr_last)
      lcnt_d = lcnt_d + CW'(1);
    if (pop && mem_last[rptr_q])
      lcnt_d = lcnt_d - CW'(1);
    ur_d = ur_q;
    if (set_ur)
      ur_d = 1'b1;
    else if (clr_underrun)
      ur_d = 1'b0;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      lcnt_q  <= '0;
      state_q <= IDLE;
      dq0_q   <= {DQ_WIDTH{INIT}};
      dq1_q   <= {DQ_WIDTH{INIT}};
      dm0_q   <= '1;
      dm1_q   <= '1;
      dqoe_q  <= 1'b0;
      dqs0_q  <= 1'b0;
      dqs1_q  <= 1'b0;
      dqsoe_q <= 1'b0;
      lbeat_q <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      lcnt_q  <= lcnt_d;
      state_q <= state_d;
      dq0_q   <= dq0_d;
      dq1_q   <= dq1_d;
      dm0_q   <= dm0_d;
      dm1_q   <= dm1_d;
      dqoe_q  <= dqoe_d;
      dqs0_q  <= dqs0_d;
      dqs1_q  <= dqs1_d;
      dqsoe_q <= dqsoe_d;
      lbeat_q <= lbeat_d;
      ur_q    <= ur_d;
    end
  end

  assign dq_d0    = dq0_q;
  assign dq_d1    = dq1_q;
  assign dm_d0    = dm0_q;
  assign dm_d1    = dm1_q;
  assign dq_oe    = dqoe_q;
  assign dqs_d0   = dqs0_q;
  assign dqs_d1   = dqs1_q;
  assign dqs_oe   = dqsoe_q;
  assign underrun = ur_q;
  assign busy     = (state_q != IDLE) | (count_q != '0);

endmodule

// File: tb/tb_hpdmc_oddr_serializer.sv
// Directed bench for hpdmc_oddr_serializer: default instance plus
// an INIT=1, START_LEVEL=4 instance for fill and reset cases.
module tb_hpdmc_oddr_serializer;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        wr_valid, wr_valid2;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        wr_last;
  logic        clr_underrun;

  logic        wr_ready, dq_oe, dqs_d0, dqs_d1, dqs_oe;
  logic        busy, underrun;
  logic [15:0] dq_d0, dq_d1;
  logic [1:0]  dm_d0, dm_d1;

  logic        wr_ready2, dq_oe2, dqs_d02, dqs_d12, dqs_oe2;
  logic        busy2, underrun2;
  logic [15:0] dq_d02, dq_d12;
  logic [1:0]  dm_d02, dm_d12;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  hpdmc_oddr_serializer dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_mask(wr_mask),
    .wr_last(wr_last), .clr_underrun(clr_underrun),
    .dq_d0(dq_d0), .dq_d1(dq_d1),
    .dm_d0(dm_d0), .dm_d1(dm_d1),
    .dq_oe(dq_oe), .dqs_d0(dqs_d0), .dqs_d1(dqs_d1),
    .dqs_oe(dqs_oe), .busy(busy), .underrun(underrun)
  );

  hpdmc_oddr_serializer #(
    .DQ_WIDTH(16), .DEPTH(4),
    .START_LEVEL(4), .INIT(1'b1)
  ) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .wr_valid(wr_valid2), .wr_ready(wr_ready2),
    .wr_data(wr_data), .wr_mask(wr_mask),
    .wr_last(wr_last), .clr_underrun(clr_underrun),
    .dq_d0(dq_d02), .dq_d1(dq_d12),
    .dm_d0(dm_d02), .dm_d1(dm_d12),
    .dq_oe(dq_oe2), .dqs_d0(dqs_d02), .dqs_d1(dqs_d12),
    .dqs_oe(dqs_oe2), .busy(busy2), .underrun(underrun2)
  );

  // ctl = {dq_oe, dqs_oe, dqs_d0, dqs_d1}
  wire [3:0] ctl  = {dq_oe, dqs_oe, dqs_d0, dqs_d1};
  wire [3:0] ctl2 = {dq_oe2, dqs_oe2, dqs_d02, dqs_d12};
  localparam logic [3:0] C_IDLE = 4'b0000;
  localparam logic [3:0] C_AMB  = 4'b0100;
  localparam logic [3:0] C_DATA = 4'b1110;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    logic [42:0] obs;
    sys_rst = 1'b1;
    wr_valid = 1'b0; wr_valid2 = 1'b0;
    wr_data = '0; wr_mask = '0;
    wr_last = 1'b0; clr_underrun = 1'b0;
    step(); step();
    sys_rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      obs = {wr_ready, dq_d0, dq_d1, dm_d0, dm_d1,
             ctl, busy, underrun};
      checks++;
      if (obs !== {1'b1, 16'h0, 16'h0, 2'b11, 2'b11,
                   C_IDLE, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got %h expected %h",
                 c, obs, {1'b1, 32'h0, 4'hF, 6'h0});
      end
    end
    checks++;
    if ({dq_d02, dq_d12} !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL reset_init1: got %h expected ffffffff",
               {dq_d02, dq_d12});
    end
  endtask

  task automatic test_single();
    wr_valid = 1'b1; wr_data = 32'hBEEF_1234;
    wr_mask = 4'h0; wr_last = 1'b1;
    step();
    wr_valid = 1'b0; wr_last = 1'b0;
    checks++;
    if ({ctl, busy} !== {C_IDLE, 1'b1}) begin
      errors++;
      $display("FAIL single_e0: got %b expected %b",
               {ctl, busy}, {C_IDLE, 1'b1});
    end
    step();
    checks++;
    if ({ctl, dm_d0, dm_d1} !== {C_AMB, 4'hF}) begin
      errors++;
      $display("FAIL single_pre: got %h expected %h",
               {ctl, dm_d0, dm_d1}, {C_AMB, 4'hF});
    end
    step();
    checks++;
    if ({ctl, dq_d0, dq_d1, dm_d0, dm_d1} !==
        {C_DATA, 16'h1234, 16'hBEEF, 4'h0}) begin
      errors++;
      $display("FAIL single_beat: got %h expected %h",
               {ctl, dq_d0, dq_d1, dm_d0, dm_d1},
               {C_DATA, 16'h1234, 16'hBEEF, 4'h0});
    end
    step();
    checks++;
    if ({ctl, dm_d0, dm_d1} !== {C_AMB, 4'hF}) begin
      errors++;
      $display("FAIL single_post: got %h expected %h",
               {ctl, dm_d0, dm_d1}, {C_AMB, 4'hF});
    end
    step();
    checks++;
    if ({ctl, busy, dq_d0} !== {C_IDLE, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL single_idle: got %h expected %h",
               {ctl, busy, dq_d0}, {C_IDLE, 1'b0, 16'h0});
    end
  endtask

  task automatic test_burst4();
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = {16'(16'h2000 + i), 16'(16'h1000 + i)};
      wr_mask  = {2'(3 - i), 2'(i)};
      wr_last  = (i == 3);
      step();
      if (i == 1) begin
        checks++;
        if (ctl !== C_IDLE) begin
          errors++;
          $display("FAIL burst4_wait: got %b expected %b",
                   ctl, C_IDLE);
        end
      end
      if (i == 2) begin
        checks++;
        if (ctl !== C_AMB) begin
          errors++;
          $display("FAIL burst4_pre: got %b expected %b",
                   ctl, C_AMB);
        end
      end
    end
    wr_valid = 1'b0; wr_last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      checks++;
      if ({ctl, dq_d0, dq_d1, dm_d0, dm_d1} !==
          {C_DATA, 16'(16'h1000 + k), 16'(16'h2000 + k),
           2'(k), 2'(3 - k)}) begin
        errors++;
        $display("FAIL burst4_beat%0d: got %h expected %h", k,
                 {ctl, dq_d0, dq_d1, dm_d0, dm_d1},
                 {C_DATA, 16'(16'h1000 + k), 16'(16'h2000 + k),
                  2'(k), 2'(3 - k)});
      end
    end
    step();
    checks++;
    if ({ctl, underrun} !== {C_AMB, 1'b0}) begin
      errors++;
      $display("FAIL burst4_post: got %b expected %b",
               {ctl, underrun}, {C_AMB, 1'b0});
    end
    step();
    checks++;
    if ({ctl, busy, underrun} !== {C_IDLE, 2'b00}) begin
      errors++;
      $display("FAIL burst4_idle: got %b expected %b",
               {ctl, busy, underrun}, {C_IDLE, 2'b00});
    end
  endtask

  task automatic test_underrun();
    wr_mask = 4'h0; wr_last = 1'b0;
    wr_valid = 1'b1; wr_data = {16'hA000, 16'h5000};
    step();
    wr_data = {16'hA001, 16'h5001};
    step();
    wr_valid = 1'b0;
    step();
    checks++;
    if (ctl !== C_AMB) begin
      errors++;
      $display("FAIL ur_pre: got %b expected %b", ctl, C_AMB);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({ctl, dq_d0, dq_d1, dm_d0, dm_d1} !==
          {C_DATA, 16'(16'h5000 + k), 16'(16'hA000 + k),
           4'h0}) begin
        errors++;
        $display("FAIL ur_beat%0d: got %h expected %h", k,
                 {ctl, dq_d0, dq_d1, dm_d0, dm_d1},
                 {C_DATA, 16'(16'h5000 + k),
                  16'(16'hA000 + k), 4'h0});
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        wr_valid = 1'b1; wr_last = 1'b1;
        wr_data = {16'hA0FF, 16'h50FF};
        wr_mask = 4'b0110;
      end
      step();
      checks++;
      if ({ctl, dm_d0, dm_d1, dq_d0, dq_d1, underrun} !==
          {C_DATA, 4'hF, 16'h5001, 16'hA001, 1'b1}) begin
        errors++;
        $display("FAIL ur_empty%0d: got %h expected %h", k,
                 {ctl, dm_d0, dm_d1, dq_d0, dq_d1, underrun},
                 {C_DATA, 4'hF, 16'h5001, 16'hA001, 1'b1});
      end
    end
    wr_valid = 1'b0; wr_last = 1'b0; wr_mask = 4'h0;
    step();
    checks++;
    if ({ctl, dq_d0, dq_d1, dm_d0, dm_d1, underrun} !==
        {C_DATA, 16'h50FF, 16'hA0FF, 2'b10, 2'b01, 1'b1}) begin
      errors++;
      $display("FAIL ur_last: got %h expected %h",
               {ctl, dq_d0, dq_d1, dm_d0, dm_d1, underrun},
               {C_DATA, 16'h50FF, 16'hA0FF, 2'b10, 2'b01, 1'b1});
    end
    step();
    step();
    checks++;
    if ({ctl, underrun} !== {C_IDLE, 1'b1}) begin
      errors++;
      $display("FAIL ur_sticky: got %b expected %b",
               {ctl, underrun}, {C_IDLE, 1'b1});
    end
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL ur_clear: got %b expected 0", underrun);
    end
  endtask

  task automatic test_back_to_back();
    wr_mask = 4'h0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = {16'(16'hCC00 + i), 16'(16'h3300 + i)};
      wr_last  = (i == 1) || (i == 3);
      step();
      if (i == 2) begin
        checks++;
        if (ctl !== C_AMB) begin
          errors++;
          $display("FAIL b2b_pre: got %b expected %b",
                   ctl, C_AMB);
        end
      end
    end
    wr_valid = 1'b0; wr_last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      checks++;
      if ({ctl, dq_d0, dq_d1, dm_d0, dm_d1} !==
          {C_DATA, 16'(16'h3300 + k), 16'(16'hCC00 + k),
           4'h0}) begin
        errors++;
        $display("FAIL b2b_beat%0d: got %h expected %h", k,
                 {ctl, dq_d0, dq_d1, dm_d0, dm_d1},
                 {C_DATA, 16'(16'h3300 + k),
                  16'(16'hCC00 + k), 4'h0});
      end
    end
    step();
    checks++;
    if (ctl !== C_AMB) begin
      errors++;
      $display("FAIL b2b_post: got %b expected %b", ctl, C_AMB);
    end
    step();
    checks++;
    if ({ctl, busy} !== {C_IDLE, 1'b0}) begin
      errors++;
      $display("FAIL b2b_idle: got %b expected %b",
               {ctl, busy}, {C_IDLE, 1'b0});
    end
  endtask

  task automatic test_full_reset();
    logic [42:0] obs;
    wr_valid = 1'b0; wr_last = 1'b0; wr_mask = 4'h0;
    wr_valid2 = 1'b1; wr_data = {16'hF00D, 16'hD00F};
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 2) begin
        checks++;
        if (wr_ready2 !== 1'b1) begin
          errors++;
          $display("FAIL full_ready3: got %b expected 1",
                   wr_ready2);
        end
      end
    end
    checks++;
    if ({wr_ready2, busy2, ctl2} !== {2'b01, C_IDLE}) begin
      errors++;
      $display("FAIL full_ready4: got %b expected %b",
               {wr_ready2, busy2, ctl2}, {2'b01, C_IDLE});
    end
    step();
    checks++;
    if ({wr_ready2, ctl2} !== {1'b0, C_AMB}) begin
      errors++;
      $display("FAIL full_pre: got %b expected %b",
               {wr_ready2, ctl2}, {1'b0, C_AMB});
    end
    step();
    wr_valid2 = 1'b0;
    checks++;
    if ({wr_ready2, ctl2, dq_d02} !==
        {1'b1, C_DATA, 16'hD00F}) begin
      errors++;
      $display("FAIL full_pop: got %h expected %h",
               {wr_ready2, ctl2, dq_d02},
               {1'b1, C_DATA, 16'hD00F});
    end
    step();
    #2;
    sys_rst = 1'b1;
    #1;
    obs = {wr_ready2, dq_d02, dq_d12, dm_d02, dm_d12,
           ctl2, busy2, underrun2};
    checks++;
    if (obs !== {1'b1, 16'hFFFF, 16'hFFFF, 2'b11, 2'b11,
                 C_IDLE, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", obs,
               {1'b1, 32'hFFFF_FFFF, 4'hF, 6'h0});
    end
    step();
    sys_rst = 1'b0;
    step(); step(); step();
    checks++;
    if ({ctl2, busy2, wr_ready2} !== {C_IDLE, 2'b01}) begin
      errors++;
      $display("FAIL reset_flush: got %b expected %b",
               {ctl2, busy2, wr_ready2}, {C_IDLE, 2'b01});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst4();
    test_underrun();
    test_back_to_back();
    test_full_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/hpdmc_oddr_serializer.md
# hpdmc_oddr_serializer

Parametrised DDR write-data launcher for the HPDMC DDR PHY. It buffers full-rate write words from the controller, each holding one rising-edge half and one falling-edge half. It then sequences them into per-lane D0/D1 pairs, data masks, DQS patterns and tristate enables, with DQS preamble and postamble. All outputs are registered and drive ODDR2 D0/D1 inputs directly. The block generalises the single-bit DDR output cell to DQ_WIDTH lanes, adds a FIFO, burst framing and underrun detection.

## Interface
- DQ_WIDTH, 16: DQ lanes; multiple of 8.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- START_LEVEL, 2: FIFO occupancy that starts a burst; 1..DEPTH.
- INIT, 1'b0: idle/reset value of every dq_d0/dq_d1 bit.
- sys_clk  in  1  sole clock; all state updates on rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  write word offered.
- wr_ready  out  1  FIFO not full.
- wr_data  in  2*DQ_WIDTH  [DQ_WIDTH-1:0] = rising beat (D0), upper half = falling beat (D1).
- wr_mask  in  DQ_WIDTH/4  [DQ_WIDTH/8-1:0] = D0 byte masks, upper half = D1; 1 = byte masked.
- wr_last  in  1  final word of burst.
- clr_underrun  in  1  clears sticky underrun flag.
- dq_d0, dq_d1  out  DQ_WIDTH  rising/falling data to ODDR2.
- dm_d0, dm_d1  out  DQ_WIDTH/8  rising/falling masks to ODDR2.
- dq_oe  out  1  DQ/DM output enable.
- dqs_d0, dqs_d1  out  1  DQS pattern to ODDR2.
- dqs_oe  out  1  DQS output enable.
- busy  out  1  state ≠ IDLE or FIFO non-empty.
- underrun  out  1  sticky: FIFO empty during DATA before last popped.

## Operation
- FIFO: DEPTH entries of {last, mask, data}; count 0..DEPTH; pointers wrap modulo DEPTH. Push = wr_valid & wr_ready; wr_ready = (count != DEPTH). Push and pop in the same cycle leave count unchanged. Pushing while full is impossible by construction. last_cnt counts entries currently held with last=1.
- States:
  - IDLE: dq_oe=0, dqs_oe=0, dq = INIT, dm = all ones, dqs = 0/0.
  - IDLE → PRE when count ≥ START_LEVEL or last_cnt ≠ 0.
  - PRE: one cycle. dqs_oe=1, dqs_d0=dqs_d1=0, dq_oe=0. PRE → DATA.
  - DATA: pops one entry per cycle when count ≠ 0. Drives dq_d0/dq_d1/dm_d0/dm_d1 from the entry, dq_oe=1, dqs_oe=1, dqs_d0=1, dqs_d1=0.
  - DATA with FIFO empty: no pop, dm = all ones, dq held at previous value, DQS keeps toggling, underrun set. Remains in DATA.
  - DATA, popped entry has last=1:
    - next entry already present → stay in DATA (seamless back-to-back bursts, no postamble).
    - otherwise → POST.
  - POST: one cycle. dqs_oe=1, dqs 0/0, dq_oe=0, dm all ones.
  - POST → PRE if the start condition holds; otherwise → IDLE.
- underrun: set on any empty-FIFO DATA cycle. Cleared by clr_underrun only when no set occurs in that cycle; set wins.
- busy = (state ≠ IDLE) | (count ≠ 0).

## Timing
- Reset (async assert, sys_clk-synchronous release): FIFO emptied, count = last_cnt = 0, state IDLE.
  - Reset output values: wr_ready=1, dq_d0/dq_d1 = {DQ_WIDTH{INIT}}, dm = all ones, dq_oe=0, dqs_d0=dqs_d1=0, dqs_oe=0, busy=0, underrun=0.
  - Reset mid-burst drops queued data immediately.
- Latency from edge E0, where the start condition becomes true (e.g. a last word is pushed into an empty FIFO):
  - E1: PRE outputs.
  - E2: first data beat.
  - Each following edge: next beat.
  - POST appears one edge after the final beat.
- wr_ready falls on the edge where count reaches DEPTH. It rises on the edge after a pop from full.
- dq_oe and dqs_oe change only at state transitions. dq_oe is never 1 without dqs_oe.

## Test plan
- Reset release, no writes → all outputs at reset values for 10 cycles; INIT=1 → dq_d0 = dq_d1 = 16'hFFFF.
- Single-word burst: push data 32'hBEEF_1234 with mask 0 and last=1 into an empty FIFO at E0 → E1 PRE; E2 dq_d0=16'h1234, dq_d1=16'hBEEF, dq_oe=1, dqs 1/0; E3 POST; E4 IDLE.
- 4-word burst with START_LEVEL=2 and continuous valid → PRE after the 2nd push; 4 consecutive beats in order; one POST; underrun stays 0.
- Underrun: push 2 words (no last), stall, push the last word 3 cycles later → dm = all ones for the empty DATA cycles, underrun=1. clr_underrun → 0 the next edge.
- Back-to-back: burst A (2 words, last) then burst B (2 words, last) queued before A's last is popped → 4 contiguous beats, no POST/PRE between them.
- Full/reset: with DEPTH=4, hold valid high while bursts are blocked → wr_ready=0 after 4 pushes. Assert sys_rst during DATA → outputs reach reset values without a clock edge, and FIFO count is 0.
